// File: rtl/interrupt_controller_pkg.sv
// Shared constants and state encoding for the interrupt controller and its
// priority encoder.
package interrupt_controller_pkg;

  localparam int PC_SIZE_DEF   = 16;
  localparam int NUM_INT_VEC   = 15;
  localparam int INT_RETURN_ID = 0;
  localparam int IRQ_ID_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } int_state_t;

endpackage

// File: rtl/int_priority_enc.sv
// Lowest-set-bit encoder: bit k maps to id k+1, so id 1 has the highest priority.
module int_priority_enc
  import interrupt_controller_pkg::*;
#(
  parameter int N = NUM_INT_VEC - 1
) (
  input  logic [N-1:0]          req,
  output logic                  found,
  output logic [IRQ_ID_W-1:0]   id
);

  // NOTE: always_comb assigns every output before any condition so no latch can be inferred.
  always_comb begin
    found = 1'b0;
    id    = '0;
    // Scan high to low so the lowest set bit is the last (winning) assignment.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        id    = IRQ_ID_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, fixed-priority interrupt source with a req/ack/return
// handshake and a writable handler vector table.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF,
  parameter int NUM_VEC = NUM_INT_VEC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_VEC-2:0]    irq_line,
  input  logic                  irq_mask_we,
  input  logic [NUM_VEC-2:0]    irq_mask_wdata,
  input  logic                  vec_we,
  input  logic [3:0]            vec_addr,
  input  logic [PC_SIZE-1:0]    vec_wdata,
  input  logic                  global_en,
  input  logic                  irq_ack,
  input  logic                  irq_return,
  output logic [PC_SIZE-1:0]    interrupt_handler [NUM_VEC],
  output logic                  irq_req,
  output logic [3:0]            irq_id,
  output logic                  in_service,
  output logic [NUM_VEC-2:0]    pending
);

  localparam int NSRC = NUM_VEC - 1;

  int_state_t          state_q, state_d;
  logic                irq_req_q, irq_req_d;
  logic [3:0]          irq_id_q, irq_id_d;
  logic                in_service_q, in_service_d;
  logic [NSRC-1:0]     pending_q, pending_d;
  logic [NSRC-1:0]     prev_q, prev_d;
  logic [NSRC-1:0]     mask_q, mask_d;
  logic [PC_SIZE-1:0]  vec_q [NUM_VEC];
  logic [PC_SIZE-1:0]  vec_d [NUM_VEC];

  logic [NSRC-1:0]     rise;
  logic [NSRC-1:0]     clr;
  logic [NSRC-1:0]     eligible;
  logic                win_found;
  logic [3:0]          win_id;
  logic                ack_take;

  assign ack_take = (state_q == REQ) && irq_ack;
  assign rise     = irq_line & ~prev_q;
  assign eligible = pending_q & mask_q;

  int_priority_enc #(.N(NSRC)) u_prio (
    .req   (eligible),
    .found (win_found),
    .id    (win_id)
  );

  // Pending set beats clear so an edge arriving in the ack cycle is not lost.
  always_comb begin
    clr = '0;
    for (int k = 0; k < NSRC; k++) begin
      clr[k] = ack_take && (irq_id_q == 4'(k + 1));
    end
    pending_d = (pending_q & ~clr) | rise;
    prev_d    = irq_line;
    mask_d    = irq_mask_we ? irq_mask_wdata : mask_q;
  end

  // Entry 0 is the return slot and is never writable; out-of-range addresses match no entry.
  always_comb begin
    vec_d    = vec_q;
    vec_d[0] = '0;
    for (int i = 1; i < NUM_VEC; i++) begin
      if (vec_we && (vec_addr == 4'(i))) vec_d[i] = vec_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_req_d    = irq_req_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    unique case (state_q)
      IDLE: begin
        if (global_en && win_found) begin
          state_d   = REQ;
          irq_req_d = 1'b1;
          irq_id_d  = win_id;
        end
      end
      // The presented id is frozen until ack, regardless of mask or enable changes.
      REQ: begin
        if (irq_ack) begin
          state_d      = SERVICE;
          irq_req_d    = 1'b0;
          in_service_d = 1'b1;
        end
      end
      SERVICE: begin
        if (irq_return) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
          irq_id_d     = 4'(INT_RETURN_ID);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the vector table is a small register file, so it takes the reset like any other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_req_q    <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      prev_q       <= '0;
      mask_q       <= '0;
      for (int i = 0; i < NUM_VEC; i++) vec_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      irq_req_q    <= irq_req_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      prev_q       <= prev_d;
      mask_q       <= mask_d;
      vec_q        <= vec_d;
    end
  end

  assign interrupt_handler = vec_q;
  assign irq_req           = irq_req_q;
  assign irq_id            = irq_id_q;
  assign in_service        = in_service_q;
  assign pending           = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: reset, handshake, priority, mask,
// request stability, set-beats-clear and reset during service.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] irq_line;
  logic        irq_mask_we;
  logic [13:0] irq_mask_wdata;
  logic        vec_we;
  logic [3:0]  vec_addr;
  logic [15:0] vec_wdata;
  logic        global_en;
  logic        irq_ack;
  logic        irq_return;
  logic [15:0] interrupt_handler [15];
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        in_service;
  logic [13:0] pending;

  int vectors = 0;
  int errors  = 0;

  interrupt_controller dut (
    .clk               (clk),
    .rst               (rst),
    .irq_line          (irq_line),
    .irq_mask_we       (irq_mask_we),
    .irq_mask_wdata    (irq_mask_wdata),
    .vec_we            (vec_we),
    .vec_addr          (vec_addr),
    .vec_wdata         (vec_wdata),
    .global_en         (global_en),
    .irq_ack           (irq_ack),
    .irq_return        (irq_return),
    .interrupt_handler (interrupt_handler),
    .irq_req           (irq_req),
    .irq_id            (irq_id),
    .in_service        (in_service),
    .pending           (pending)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_return();
    irq_return = 1'b1;
    step();
    irq_return = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (interrupt_handler[i] !== 16'h0) begin
        $display("FAIL reset_vec[%0d]: got %h expected 0000", i, interrupt_handler[i]);
        errors++;
      end
    end
    vectors++;
    if (irq_req !== 1'b0 || irq_id !== 4'd0 || in_service !== 1'b0) begin
      $display("FAIL reset_ctl: req=%b id=%0d insvc=%b expected 0/0/0", irq_req, irq_id, in_service);
      errors++;
    end
    vectors++;
    if (pending !== 14'h0) begin
      $display("FAIL reset_pending: got %h expected 0000", pending);
      errors++;
    end
  endtask

  task automatic test_basic();
    vec_we = 1'b1; vec_addr = 4'd3; vec_wdata = 16'h0400;
    irq_mask_we = 1'b1; irq_mask_wdata = 14'h3FFF;
    global_en = 1'b1;
    step();
    vec_we = 1'b0; irq_mask_we = 1'b0;
    vectors++;
    if (interrupt_handler[3] !== 16'h0400) begin
      $display("FAIL basic_vec3: got %h expected 0400", interrupt_handler[3]);
      errors++;
    end
    irq_line[2] = 1'b1;
    step();
    irq_line[2] = 1'b0;
    vectors++;
    if (pending !== 14'h0004 || irq_req !== 1'b0) begin
      $display("FAIL basic_pend: pending=%h req=%b expected 0004/0", pending, irq_req);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      $display("FAIL basic_req: req=%b id=%0d expected 1/3", irq_req, irq_id);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      $display("FAIL basic_hold: req=%b id=%0d expected 1/3", irq_req, irq_id);
      errors++;
    end
    do_ack();
    vectors++;
    if (in_service !== 1'b1 || irq_req !== 1'b0 || pending !== 14'h0 || irq_id !== 4'd3) begin
      $display("FAIL basic_ack: insvc=%b req=%b pending=%h id=%0d expected 1/0/0000/3",
               in_service, irq_req, pending, irq_id);
      errors++;
    end
    // A stray ack during service must have no effect.
    do_ack();
    step();
    vectors++;
    if (in_service !== 1'b1 || irq_id !== 4'd3) begin
      $display("FAIL basic_svc: insvc=%b id=%0d expected 1/3", in_service, irq_id);
      errors++;
    end
    do_return();
    vectors++;
    if (in_service !== 1'b0 || irq_id !== 4'd0 || irq_req !== 1'b0) begin
      $display("FAIL basic_ret: insvc=%b id=%0d req=%b expected 0/0/0", in_service, irq_id, irq_req);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b0) begin
      $display("FAIL basic_idle: req=%b expected 0", irq_req);
      errors++;
    end
  endtask

  task automatic test_priority();
    irq_line = 14'h0012;
    step();
    irq_line = 14'h0;
    vectors++;
    if (pending !== 14'h0012) begin
      $display("FAIL prio_pend: got %h expected 0012", pending);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd2) begin
      $display("FAIL prio_first: req=%b id=%0d expected 1/2", irq_req, irq_id);
      errors++;
    end
    do_ack();
    vectors++;
    if (pending !== 14'h0010 || in_service !== 1'b1) begin
      $display("FAIL prio_ack: pending=%h insvc=%b expected 0010/1", pending, in_service);
      errors++;
    end
    step();
    do_return();
    vectors++;
    if (irq_req !== 1'b0 || irq_id !== 4'd0 || in_service !== 1'b0) begin
      $display("FAIL prio_ret: req=%b id=%0d insvc=%b expected 0/0/0", irq_req, irq_id, in_service);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd5) begin
      $display("FAIL prio_second: req=%b id=%0d expected 1/5", irq_req, irq_id);
      errors++;
    end
    do_ack();
    do_return();
    step();
  endtask

  task automatic test_mask();
    irq_mask_we = 1'b1; irq_mask_wdata = 14'h3FF7;
    step();
    irq_mask_we = 1'b0;
    irq_line[3] = 1'b1;
    step();
    irq_line[3] = 1'b0;
    step();
    step();
    vectors++;
    if (pending !== 14'h0008 || irq_req !== 1'b0) begin
      $display("FAIL mask_block: pending=%h req=%b expected 0008/0", pending, irq_req);
      errors++;
    end
    irq_mask_we = 1'b1; irq_mask_wdata = 14'h3FFF;
    step();
    irq_mask_we = 1'b0;
    vectors++;
    if (irq_req !== 1'b0) begin
      $display("FAIL mask_early: req=%b expected 0", irq_req);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd4) begin
      $display("FAIL mask_req: req=%b id=%0d expected 1/4", irq_req, irq_id);
      errors++;
    end
    do_ack();
    do_return();
    step();
  endtask

  task automatic test_req_stable();
    irq_line[5] = 1'b1;
    step();
    irq_line[5] = 1'b0;
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd6) begin
      $display("FAIL stable_req: req=%b id=%0d expected 1/6", irq_req, irq_id);
      errors++;
    end
    irq_mask_we = 1'b1; irq_mask_wdata = 14'h0; global_en = 1'b0;
    step();
    irq_mask_we = 1'b0;
    vec_we = 1'b1; vec_addr = 4'd0; vec_wdata = 16'hFFFF;
    step();
    vec_addr = 4'd15;
    step();
    vec_we = 1'b0;
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd6) begin
      $display("FAIL stable_hold: req=%b id=%0d expected 1/6", irq_req, irq_id);
      errors++;
    end
    vectors++;
    if (interrupt_handler[0] !== 16'h0 || interrupt_handler[14] !== 16'h0 || interrupt_handler[3] !== 16'h0400) begin
      $display("FAIL stable_vec: e0=%h e14=%h e3=%h expected 0000/0000/0400",
               interrupt_handler[0], interrupt_handler[14], interrupt_handler[3]);
      errors++;
    end
    do_ack();
    vectors++;
    if (in_service !== 1'b1 || irq_id !== 4'd6) begin
      $display("FAIL stable_ack: insvc=%b id=%0d expected 1/6", in_service, irq_id);
      errors++;
    end
    do_return();
    irq_mask_we = 1'b1; irq_mask_wdata = 14'h3FFF; global_en = 1'b1;
    step();
    irq_mask_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    irq_line[2] = 1'b1;
    step();
    irq_line[2] = 1'b0;
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      $display("FAIL b2b_req: req=%b id=%0d expected 1/3", irq_req, irq_id);
      errors++;
    end
    irq_ack = 1'b1; irq_line[2] = 1'b1;
    step();
    irq_ack = 1'b0; irq_line[2] = 1'b0;
    vectors++;
    if (pending !== 14'h0004 || in_service !== 1'b1) begin
      $display("FAIL b2b_setwins: pending=%h insvc=%b expected 0004/1", pending, in_service);
      errors++;
    end
    step();
    do_return();
    vectors++;
    if (irq_req !== 1'b0 || in_service !== 1'b0) begin
      $display("FAIL b2b_ret: req=%b insvc=%b expected 0/0", irq_req, in_service);
      errors++;
    end
    step();
    vectors++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      $display("FAIL b2b_rereq: req=%b id=%0d expected 1/3", irq_req, irq_id);
      errors++;
    end
    do_ack();
  endtask

  task automatic test_reset_service();
    vectors++;
    if (in_service !== 1'b1) begin
      $display("FAIL rsvc_pre: insvc=%b expected 1", in_service);
      errors++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (in_service !== 1'b0 || irq_req !== 1'b0 || irq_id !== 4'd0 || pending !== 14'h0) begin
      $display("FAIL rsvc_out: insvc=%b req=%b id=%0d pending=%h expected 0/0/0/0000",
               in_service, irq_req, irq_id, pending);
      errors++;
    end
    vectors++;
    if (interrupt_handler[3] !== 16'h0) begin
      $display("FAIL rsvc_vec3: got %h expected 0000", interrupt_handler[3]);
      errors++;
    end
    // Mask was cleared by reset, so a fresh edge pends but raises nothing.
    irq_line[0] = 1'b1;
    step();
    irq_line[0] = 1'b0;
    step();
    step();
    vectors++;
    if (pending !== 14'h0001 || irq_req !== 1'b0) begin
      $display("FAIL rsvc_mask: pending=%h req=%b expected 0001/0", pending, irq_req);
      errors++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    irq_line       = '0;
    irq_mask_we    = 1'b0;
    irq_mask_wdata = '0;
    vec_we         = 1'b0;
    vec_addr       = '0;
    vec_wdata      = '0;
    global_en      = 1'b0;
    irq_ack        = 1'b0;
    irq_return     = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_req_stable();
    test_back_to_back();
    test_reset_service();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
